nibble_serial_adder_seq: RTL

- Sequencer placed directly upstream of the 4-bit ripple-carry adder.
- Adds or subtracts wide operands one nibble per cycle. Each cycle it drives the adder's A/B/CIN and captures the adder's SUM/COUT.
- Carry is held in a flip-flop between nibbles.
- The adder stays external. Its ports connect to ADD_* on this block, so the shared adder stays a separate gate-level instance for fault simulation.

---
 rtl/nibble_serial_adder_seq_if.sv | 37 +++
 rtl/nibble_serial_adder_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : nibble_serial_adder_seq_if
// Purpose  : Request/result bundle for the nibble-serial add/subtract
//            sequencer.
// Signals  : start, sub, cin_in, op_a, op_b  (requester -> sequencer)
//            busy, done, result, carry_out, ovf (sequencer -> requester)
// Modports : master = requester side, slave = sequencer side
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface nibble_serial_adder_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic         cin_in;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         ovf;

  modport master (
    output start, sub, cin_in, op_a, op_b,
    input  busy, done, result, carry_out, ovf
  );

  modport slave (
    input  start, sub, cin_in, op_a, op_b,
    output busy, done, result, carry_out, ovf
  );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : nibble_serial_adder_seq
// Purpose  : Adds or subtracts two W-bit operands one nibble per cycle using
//            an external 4-bit adder. The inter-nibble carry is kept in a
//            flip-flop; the adder itself stays outside this block.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            bus (slave)        - start/sub/cin_in/op_a/op_b request,
//                                 busy/done/result/carry_out/ovf response
//            add_a/add_b/add_cin - nibble operands and carry to the adder
//            add_sum/add_cout    - adder response (combinational)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module nibble_serial_adder_seq #(
  parameter int NIBBLES = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  nibble_serial_adder_seq_if.slave   bus,
  output logic [3:0]                 add_a,
  output logic [3:0]                 add_b,
  output logic                       add_cin,
  input  wire logic [3:0]            add_sum,
  input  wire logic                  add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] C_LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_bx;        // B, already inverted for subtraction
  logic [W-1:0]  r_result;
  logic          r_carry_out;
  logic          r_ovf;
  logic          w_last;

  assign w_last = (r_idx == C_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and outputs. The adder operands come only from registers and
  // are forced to zero outside RUN so the adder sits quiescent.
  always_comb begin
    w_next   = r_state;
    add_a    = 4'd0;
    add_b    = 4'd0;
    add_cin  = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        bus.busy = 1'b1;
        add_a    = r_a[{r_idx, 2'b00} +: 4];
        add_b    = r_bx[{r_idx, 2'b00} +: 4];
        add_cin  = r_carry;
        if (w_last) begin
          w_next = S_FIN;
        end
      end
      S_FIN: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_bx        <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a         <= bus.op_a;
            r_bx        <= bus.sub ? ~bus.op_b : bus.op_b;
            // Subtraction is A + ~B + 1, so the carry is forced to 1.
            r_carry     <= bus.sub | bus.cin_in;
            r_idx       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
          end
        end
        S_RUN: begin
          r_result[{r_idx, 2'b00} +: 4] <= add_sum;
          r_carry                       <= add_cout;
          if (w_last) begin
            r_carry_out <= add_cout;
            // Overflow: operands share a sign that the result does not.
            r_ovf       <= (r_a[W-1] == r_bx[W-1]) && (add_sum[3] != r_a[W-1]);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire
